// File: rtl/sleep_pkg.sv
// rtl/sleep_pkg.sv - state encoding and default constants for the sleep sequencer
package sleep_pkg;

  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int DEF_DRAIN_MAX    = 32;
  localparam int DEF_WAKE_CYCLES  = 4;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_IRQ_W        = 4;

  // Width of the sleep_cycles residency counter
  localparam int SLEEP_CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_ACTIVE = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SLEEP  = 3'd3,
    ST_WAKE   = 3'd4
  } state_e;

endpackage

// File: rtl/sleep_sequencer_sat_counter.sv
// rtl/sleep_sequencer_sat_counter.sv - clearable up-counter that saturates at a runtime max
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] q
);

  // Clear wins over increment; hold once the max value is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != max)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sleep_sequencer.sv
// rtl/sleep_sequencer.sv - drains the core pipeline, gates its clock and wakes it on interrupt
module sleep_sequencer
  import sleep_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int DRAIN_MAX    = DEF_DRAIN_MAX,
  parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int IRQ_W        = DEF_IRQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wfi_req,
  input  logic                   auto_sleep_en,
  input  logic                   pipe_idle,
  input  logic                   pipe_empty,
  input  logic [IRQ_W-1:0]       irq_pending,
  input  logic [IRQ_W-1:0]       irq_mask,
  output logic                   fetch_stall,
  output logic                   clk_en,
  output logic                   sleep_req,
  output logic                   wake_req,
  output logic                   wake_done,
  output logic                   drain_abort,
  output logic [SLEEP_CNT_W-1:0] sleep_cycles,
  output logic [2:0]             state_out
);

  localparam logic [CNT_W-1:0]       IDLE_MAX   = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0]       DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0]       WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [SLEEP_CNT_W-1:0] SLEEP_SAT  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic             drain_abort_q, drain_abort_d;
  logic [CNT_W-1:0] idle_cnt;
  logic             irq_hit, trigger;
  logic             idle_clr, idle_inc;
  logic             slp_clr, slp_inc;

  assign irq_hit = |(irq_pending & irq_mask);
  assign trigger = wfi_req | (auto_sleep_en & (idle_cnt == IDLE_MAX));

  // Idle run length only counts while ACTIVE and is dropped the moment we leave it
  assign idle_inc = pipe_idle && (state_q == ST_ACTIVE);
  assign idle_clr = !pipe_idle || (state_q != ST_ACTIVE) || (state_d != ST_ACTIVE);
  assign slp_inc  = (state_q == ST_SLEEP);

  sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (idle_clr),
    .inc (idle_inc),
    .max (IDLE_MAX),
    .q   (idle_cnt)
  );

  sat_counter #(.W(SLEEP_CNT_W)) u_sleep_cnt (
    .clk (clk),
    .rst (rst),
    .clr (slp_clr),
    .inc (slp_inc),
    .max (SLEEP_SAT),
    .q   (sleep_cycles)
  );

  // State, drain/wake counters and the registered abort pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_ACTIVE;
      drain_cnt_q   <= '0;
      wake_cnt_q    <= '0;
      drain_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      drain_abort_q <= drain_abort_d;
    end
  end

  // Next-state logic; an interrupt during DRAIN cancels entry without an abort pulse
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    drain_abort_d = 1'b0;
    slp_clr       = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (trigger && !irq_hit) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
          slp_clr     = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + CNT_W'(1);
        if (irq_hit) begin
          state_d = ST_ACTIVE;
        end else if (pipe_empty) begin
          state_d = ST_GATE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d       = ST_ACTIVE;
          drain_abort_d = 1'b1;
        end
      end
      ST_GATE: begin
        state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (irq_hit) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        wake_cnt_d = wake_cnt_q + CNT_W'(1);
        if (wake_cnt_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Moore outputs decoded from registered state and counters only
  always_comb begin
    fetch_stall = 1'b1;
    clk_en      = 1'b1;
    sleep_req   = 1'b0;
    wake_req    = 1'b0;
    wake_done   = 1'b0;
    case (state_q)
      ST_ACTIVE: fetch_stall = 1'b0;
      ST_GATE:   sleep_req   = 1'b1;
      ST_SLEEP:  clk_en      = 1'b0;
      ST_WAKE: begin
        wake_req  = (wake_cnt_q == '0);
        wake_done = (wake_cnt_q == WAKE_LAST);
      end
      ST_DRAIN:  fetch_stall = 1'b1;
      default:   fetch_stall = 1'b0;
    endcase
  end

  assign drain_abort = drain_abort_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_sleep_sequencer.sv
// tb/tb_sleep_sequencer.sv - directed self-checking bench for sleep_sequencer
module tb_sleep_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wfi_req, auto_sleep_en, pipe_idle, pipe_empty;
  logic [3:0]  irq_pending, irq_mask;
  logic        fetch_stall, clk_en, sleep_req, wake_req, wake_done, drain_abort;
  logic [15:0] sleep_cycles;
  logic [2:0]  state_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sleep_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .wfi_req       (wfi_req),
    .auto_sleep_en (auto_sleep_en),
    .pipe_idle     (pipe_idle),
    .pipe_empty    (pipe_empty),
    .irq_pending   (irq_pending),
    .irq_mask      (irq_mask),
    .fetch_stall   (fetch_stall),
    .clk_en        (clk_en),
    .sleep_req     (sleep_req),
    .wake_req      (wake_req),
    .wake_done     (wake_done),
    .drain_abort   (drain_abort),
    .sleep_cycles  (sleep_cycles),
    .state_out     (state_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wfi_req = 1'b0; auto_sleep_en = 1'b0; pipe_idle = 1'b0;
    pipe_empty = 1'b0; irq_pending = 4'b0; irq_mask = 4'b0;
    #1;
    chk("rst_state", 16'(state_out), 16'd0);
    chk("rst_clk_en", 16'(clk_en), 16'd1);
    chk("rst_fetch_stall", 16'(fetch_stall), 16'd0);
    chk("rst_sleep_req", 16'(sleep_req), 16'd0);
    chk("rst_wake_req", 16'(wake_req), 16'd0);
    chk("rst_wake_done", 16'(wake_done), 16'd0);
    chk("rst_drain_abort", 16'(drain_abort), 16'd0);
    chk("rst_sleep_cycles", sleep_cycles, 16'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Full WFI sequence: 3 DRAIN cycles, 10 SLEEP cycles, 4 WAKE cycles
    wfi_req = 1'b1;
    tick();
    chk("t1_drain1", 16'(state_out), 16'd1);
    chk("t1_fetch_stall", 16'(fetch_stall), 16'd1);
    wfi_req = 1'b0;
    tick();
    tick();
    chk("t1_drain3", 16'(state_out), 16'd1);
    pipe_empty = 1'b1;
    tick();
    chk("t1_gate", 16'(state_out), 16'd2);
    chk("t1_sleep_req", 16'(sleep_req), 16'd1);
    chk("t1_gate_clk_en", 16'(clk_en), 16'd1);
    pipe_empty = 1'b0;
    tick();
    chk("t1_sleep", 16'(state_out), 16'd3);
    chk("t1_sleep_clk_en", 16'(clk_en), 16'd0);
    chk("t1_sleep_req_low", 16'(sleep_req), 16'd0);
    repeat (9) tick();
    chk("t1_still_sleep", 16'(state_out), 16'd3);
    irq_pending = 4'b0100; irq_mask = 4'b0100;
    tick();
    chk("t1_wake", 16'(state_out), 16'd4);
    chk("t1_wake_req", 16'(wake_req), 16'd1);
    chk("t1_wake_clk_en", 16'(clk_en), 16'd1);
    chk("t1_sleep_cycles", sleep_cycles, 16'd10);
    irq_pending = 4'b0;
    tick();
    chk("t1_wake_req_drop", 16'(wake_req), 16'd0);
    chk("t1_wake_no_abort", 16'(state_out), 16'd4);
    tick();
    chk("t1_wake_done_early", 16'(wake_done), 16'd0);
    tick();
    chk("t1_wake_done", 16'(wake_done), 16'd1);
    tick();
    chk("t1_active", 16'(state_out), 16'd0);
    chk("t1_fetch_resume", 16'(fetch_stall), 16'd0);
    chk("t1_wake_done_drop", 16'(wake_done), 16'd0);
    chk("t1_sleep_cycles_hold", sleep_cycles, 16'd10);

    // Idle timeout: an interrupted idle run must not trigger, a full one must
    auto_sleep_en = 1'b1; pipe_idle = 1'b1;
    repeat (14) tick();
    pipe_idle = 1'b0;
    tick();
    chk("t2_no_trigger", 16'(state_out), 16'd0);
    pipe_idle = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("t2_idle_active_%0d", i), 16'(state_out), 16'd0);
    end
    tick();
    chk("t2_auto_drain", 16'(state_out), 16'd1);
    chk("t2_sleep_cycles_clr", sleep_cycles, 16'd0);
    auto_sleep_en = 1'b0; pipe_idle = 1'b0;
    irq_pending = 4'b0001; irq_mask = 4'b0001;
    tick();
    chk("t2_irq_cancel", 16'(state_out), 16'd0);
    chk("t2_irq_no_abort", 16'(drain_abort), 16'd0);

    // WFI with a masked-in pending irq is a NOP; masked-out it enters DRAIN
    wfi_req = 1'b1;
    tick();
    chk("t4_wfi_nop", 16'(state_out), 16'd0);
    irq_mask = 4'b0000;
    tick();
    chk("t4_wfi_masked", 16'(state_out), 16'd1);
    wfi_req = 1'b0; irq_pending = 4'b0;
    tick();

    // Drain timeout with pipe_empty held low
    tick();
    chk("t3_drain_start", 16'(state_out), 16'd1);
    // DUT still in DRAIN from previous step; restart cleanly via irq first
    irq_pending = 4'b0001; irq_mask = 4'b0001;
    tick();
    chk("t3_back_active", 16'(state_out), 16'd0);
    irq_pending = 4'b0; irq_mask = 4'b0;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("t3_drain", 16'(state_out), 16'd1);
    repeat (31) tick();
    chk("t3_drain_last", 16'(state_out), 16'd1);
    chk("t3_no_abort_yet", 16'(drain_abort), 16'd0);
    tick();
    chk("t3_abort_state", 16'(state_out), 16'd0);
    chk("t3_abort_pulse", 16'(drain_abort), 16'd1);
    chk("t3_abort_fetch", 16'(fetch_stall), 16'd0);
    tick();
    chk("t3_abort_drop", 16'(drain_abort), 16'd0);

    // Interrupt arriving in GATE: one SLEEP cycle then WAKE
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0; pipe_empty = 1'b1;
    tick();
    pipe_empty = 1'b0;
    irq_pending = 4'b0100; irq_mask = 4'b0100;
    chk("t5_gate", 16'(state_out), 16'd2);
    chk("t5_gate_no_wake_req", 16'(wake_req), 16'd0);
    tick();
    chk("t5_sleep", 16'(state_out), 16'd3);
    chk("t5_sleep_clk_en", 16'(clk_en), 16'd0);
    chk("t5_sleep_no_wake_req", 16'(wake_req), 16'd0);
    tick();
    chk("t5_wake", 16'(state_out), 16'd4);
    chk("t5_wake_req", 16'(wake_req), 16'd1);
    chk("t5_wake_no_sleep_req", 16'(sleep_req), 16'd0);
    chk("t5_sleep_cycles", sleep_cycles, 16'd1);
    irq_pending = 4'b0; irq_mask = 4'b0;
    repeat (3) tick();
    chk("t5_wake_done", 16'(wake_done), 16'd1);
    tick();
    chk("t5_active", 16'(state_out), 16'd0);

    // Asynchronous reset while sleeping, then a fresh sequence
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0; pipe_empty = 1'b1;
    tick();
    pipe_empty = 1'b0;
    tick();
    repeat (3) tick();
    chk("t6_sleep", 16'(state_out), 16'd3);
    chk("t6_sleep_clk_en", 16'(clk_en), 16'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_state", 16'(state_out), 16'd0);
    chk("t6_rst_clk_en", 16'(clk_en), 16'd1);
    chk("t6_rst_fetch", 16'(fetch_stall), 16'd0);
    chk("t6_rst_sleep_cycles", sleep_cycles, 16'd0);
    #2 rst = 1'b1;
    tick();
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("t6_restart_drain", 16'(state_out), 16'd1);
    pipe_empty = 1'b1;
    tick();
    pipe_empty = 1'b0;
    chk("t6_restart_gate", 16'(sleep_req), 16'd1);
    tick();
    chk("t6_restart_sleep", 16'(state_out), 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sleep_sequencer.md
Name: sleep_sequencer

Overview:
Power-management sequencer for the pipelined RV32I core. It decides when the core may sleep and safely drains the pipeline before sleeping. It drives the sleep_request/wakeup_request inputs of the existing two-state sleep controller, gates the core clock enable, and wakes the core on a masked interrupt. Sleep is entered on a WFI request or, optionally, after an idle timeout.

Parameters:
IDLE_TIMEOUT, 16, consecutive pipe_idle cycles before an auto-sleep trigger (valid range 1..2^CNT_W-1)
DRAIN_MAX, 32, maximum DRAIN cycles before the entry is aborted (valid range 1..2^CNT_W-1)
WAKE_CYCLES, 4, cycles spent in WAKE before the core resumes (valid range 1..2^CNT_W-1)
CNT_W, 8, width of the idle, drain and wake counters
IRQ_W, 4, number of interrupt lines

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
wfi_req  in  1  one-cycle pulse from EX when a WFI instruction executes
auto_sleep_en  in  1  enables the idle-timeout trigger
pipe_idle  in  1  no valid instruction in IF/ID this cycle
pipe_empty  in  1  all pipeline stages empty, no outstanding memory access
irq_pending  in  IRQ_W  level interrupt lines
irq_mask  in  IRQ_W  1 = line may wake the core
fetch_stall  out  1  holds PC and blocks fetch
clk_en  out  1  core clock-gate enable
sleep_req  out  1  to Sleep_Controller sleep_request
wake_req  out  1  to Sleep_Controller wakeup_request
wake_done  out  1  one-cycle pulse when the core resumes
drain_abort  out  1  one-cycle pulse when a drain times out
sleep_cycles  out  16  saturating count of cycles spent in the last SLEEP
state_out  out  3  current state, for debug

Behaviour:
- States (3-bit): ACTIVE=0, DRAIN=1, GATE=2, SLEEP=3, WAKE=4. Unused encodings go to ACTIVE.
- Outputs are Moore-style, decoded from registered state and counters only; there is no combinational input-to-output path.
- Reset (rst=0, async): state ACTIVE, all counters 0, sleep_cycles 0, clk_en=1, all other outputs 0. Reset mid-sequence, including in SLEEP, returns immediately to ACTIVE with clk_en=1.
- irq_hit = |(irq_pending & irq_mask).
- idle_cnt, in ACTIVE:
  - increments while pipe_idle=1 and saturates at IDLE_TIMEOUT;
  - clears when pipe_idle=0;
  - clears on leaving ACTIVE.
- trigger = wfi_req | (auto_sleep_en & idle_cnt==IDLE_TIMEOUT).
- ACTIVE: fetch_stall=0, clk_en=1.
  - trigger & !irq_hit -> DRAIN; clear drain_cnt and sleep_cycles.
  - trigger & irq_hit -> stay in ACTIVE (WFI behaves as a NOP).
- DRAIN: fetch_stall=1, drain_cnt increments each cycle.
  - irq_hit -> ACTIVE, no pulse. irq_hit has priority over both transitions below.
  - pipe_empty -> GATE.
  - drain_cnt==DRAIN_MAX-1 and !pipe_empty -> ACTIVE with drain_abort=1 for 1 cycle.
- GATE: exactly 1 cycle. sleep_req=1, fetch_stall=1, clk_en=1. Always -> SLEEP; an irq arriving in GATE is serviced from SLEEP on the next cycle.
- SLEEP: clk_en=0, fetch_stall=1. sleep_cycles increments each cycle and saturates at 0xFFFF. irq_hit -> WAKE and clear wake_cnt.
- WAKE: clk_en=1, fetch_stall=1.
  - wake_req=1 only in the first WAKE cycle (wake_cnt==0).
  - wake_cnt increments each cycle.
  - wake_done=1 in the cycle where wake_cnt==WAKE_CYCLES-1; next state ACTIVE.
  - An irq dropping during WAKE does not abort the wake.
- Latencies:
  - wfi_req to DRAIN: 1 cycle.
  - pipe_empty to sleep_req: 1 cycle.
  - sleep_req to clk_en=0: 1 cycle.
  - irq_hit to wake_req: 1 cycle.
  - wake_req to fetch_stall=0: WAKE_CYCLES cycles.
- sleep_req and wake_req are never high in the same cycle.

Decomposition:
- Package sleep_pkg holds the state encoding localparams and the default parameter constants. sleep_cycles width (16) is fixed here.
- One sub-module is natural: sat_counter (parameter W; ports clk, rst, clr, inc, max, q; saturates at max). It is instantiated for idle_cnt and sleep_cycles.
- drain_cnt and wake_cnt stay inline.

Test Plan:
- wfi_req pulse, pipe_empty=1 after 3 cycles, irq[2] unmasked at SLEEP+10 -> states 0,1,1,1,2,3,...,4,4,4,4,0; sleep_req one cycle; clk_en=0 during SLEEP; wake_req then wake_done 3 cycles later; sleep_cycles=10.
- auto_sleep_en=1, pipe_idle=1 for 16 cycles -> DRAIN on cycle 17; with pipe_idle dropping at cycle 15 -> no trigger, idle_cnt=0.
- wfi_req, pipe_empty held 0 -> drain_abort pulse after 32 DRAIN cycles, state ACTIVE, fetch_stall=0.
- wfi_req while irq_pending=4'b0001, irq_mask=4'b0001 -> stay ACTIVE; same with mask=0 -> DRAIN.
- irq asserted during GATE -> SLEEP for 1 cycle (sleep_cycles=1), then WAKE; wake_req is never coincident with sleep_req.
- rst=0 asserted in SLEEP -> same cycle state_out=0, clk_en=1; after release, wfi_req restarts a normal sequence.
